wta_window_classifier: RTL and testbench
========================================

Name: wta_window_classifier

Overview:
- Windowed winner-take-all classifier for the SNN output layer. Counts spikes per output node over a programmable window, then finds the winning node with a sequential argmax scan (one node per cycle, no wide comparator tree).
- Reports the winner index and its count, and gates the winner's live spike onto spike_o.
- Two modes: max-count, and first-to-spike (early exit). Successor to the single-shot free-running winner selector: adds windowing, a handshake, saturation, defined tie-break and a no-winner flag.

Parameters:
- NUM_NODES, 10, number of output nodes (>=1)
- CNT_W, 16, per-node spike counter width (saturating)
- WIN_W, 16, width of the window-length input

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- nodes_i  in  NUM_NODES  spike vector, one bit per node per cycle
- start_i  in  1  start a classification window (accepted only in IDLE)
- mode_i  in  1  0 = max-count, 1 = first-to-spike; sampled when start is accepted
- window_len_i  in  WIN_W  window length in cycles; sampled when start is accepted
- busy_o  out  1  high while not IDLE
- valid_o  out  1  one-cycle pulse when a result is ready
- winner_o  out  $clog2(NUM_NODES) (min 1)  winning node index, held until the next accepted start
- winner_cnt_o  out  CNT_W  count of the winning node, held with winner_o
- no_winner_o  out  1  result had zero spikes, held with winner_o
- spike_o  out  1  nodes_i[winner_o] when have_result & !no_winner_o, else 0 (combinational)

Behaviour:
- Reset: all outputs 0; counters 0; state IDLE; have_result 0. Reset mid-window aborts the window and discards all partial state.
- FSM states: IDLE, COUNT, SCAN, DONE.
- IDLE, start_i=1, window_len_i!=0:
  - latch mode and length into win_cnt;
  - clear counters; clear have_result;
  - go to COUNT.
- IDLE, start_i=1, window_len_i=0: start ignored, stay IDLE.
- start_i outside IDLE is ignored.
- Start accepted at cycle T: counting runs on cycles T+1 .. T+L inclusive.
- COUNT:
  - each cycle, node_cnt[i] += nodes_i[i], saturating at 2^CNT_W-1;
  - win_cnt decrements; after the L-th count cycle, go to SCAN.
- COUNT, mode 1: on the first cycle with nodes_i != 0, the lowest set index is the winner. That cycle's spikes are still counted. Skip SCAN and go to DONE. If the window expires with no spike, go to SCAN, which yields no_winner.
- SCAN (mode 0, or mode 1 with no spike):
  - idx runs 0..NUM_NODES-1, one node per cycle; best starts at count 0, index 0;
  - replace best only when node_cnt[idx] > best (strictly greater), so ties go to the lowest index;
  - after idx = NUM_NODES-1, go to DONE. SCAN takes NUM_NODES cycles.
- DONE (one cycle):
  - register winner_o, winner_cnt_o, no_winner_o (=1 iff best count is 0);
  - set have_result; pulse valid_o;
  - go to IDLE.
- Latency, mode 0: valid_o at cycle T+L+NUM_NODES+1.
- Latency, mode 1 with first spike at cycle S: valid_o at S+1.
- DONE→IDLE followed by start in the same IDLE cycle is legal: back-to-back windows with one idle cycle.
- Counters do not increment outside COUNT.
- Saturated counts compare equal; the lowest index wins.

Decomposition:
- Package wta_pkg: state enum type (IDLE/COUNT/SCAN/DONE), mode constants MODE_MAX=0 and MODE_FIRST=1, and a function for the index width (max(1, $clog2(n))).
- One sub-module: wta_sat_counter (CNT_W-bit saturating counter with clr and inc), instantiated NUM_NODES times in a generate loop.
- The FSM and scan logic stay in the top module.

Test Plan:
- Max-count: NUM_NODES=4, L=8, node2 spikes 5x, node1 3x, others 0 → valid_o at T+13, winner_o=2, winner_cnt_o=5, no_winner_o=0.
- Tie: node1 and node3 each spike 4x, L=6 → winner_o=1 (lowest index), winner_cnt_o=4.
- First-to-spike: mode_i=1, L=20, nodes_i=4'b1010 at cycle T+3 → valid_o at T+4, winner_o=1, winner_cnt_o=1; then spike_o follows nodes_i[1].
- Edge cases: window with all-zero input (mode 0, L=5) → winner_o=0, winner_cnt_o=0, no_winner_o=1, spike_o held 0. CNT_W=3, node0 spikes every cycle with L=12 → winner_cnt_o=7 (saturated).
- Handshake: start_i with window_len_i=0 → busy_o stays 0. start_i during COUNT → ignored and the result is unchanged. Reset asserted mid-SCAN → next cycle all outputs 0, state IDLE.
- Back-to-back: second start one cycle after valid_o → prior winner_o held until that start is accepted, then a new result matching the second stimulus.

Source files
------------

// File: rtl/wta_pkg.sv
// Shared types and helpers for the windowed winner-take-all classifier.
// FSM state encoding, mode constants and index-width helper.
package wta_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic MODE_MAX   = 1'b0;
  localparam logic MODE_FIRST = 1'b1;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wta_sat_counter.sv
// Per-node spike counter that sticks at all-ones instead of wrapping.
// Clear has priority over increment.
module wta_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: rtl/wta_window_classifier.sv
// Windowed winner-take-all classifier: counts spikes per node over a window,
// then picks the winner by a one-node-per-cycle argmax scan or first spike.
module wta_window_classifier
  import wta_pkg::*;
#(
  parameter int NUM_NODES = 10,
  parameter int CNT_W     = 16,
  parameter int WIN_W     = 16,
  localparam int IDX_W    = idx_width(NUM_NODES)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_NODES-1:0] nodes_i,
  input  logic                 start_i,
  input  logic                 mode_i,
  input  logic [WIN_W-1:0]     window_len_i,
  output logic                 busy_o,
  output logic                 valid_o,
  output logic [IDX_W-1:0]     winner_o,
  output logic [CNT_W-1:0]     winner_cnt_o,
  output logic                 no_winner_o,
  output logic                 spike_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);

  state_e           state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic             mode_q, mode_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
  logic [IDX_W-1:0] first_idx, res_idx;
  logic [CNT_W-1:0] res_cnt, scan_cnt;
  logic             start_ok, res_we, cnt_en;
  logic             have_result;

  logic [CNT_W-1:0] node_cnt [NUM_NODES];

  assign cnt_en = (state_q == COUNT);

  for (genvar g = 0; g < NUM_NODES; g++) begin : g_cnt
    wta_sat_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .clr_i(start_ok),
      .inc_i(cnt_en & nodes_i[g]),
      .cnt_o(node_cnt[g])
    );
  end

  assign scan_cnt = node_cnt[idx_q];

  // Walk downwards so the lowest set index is the one left standing.
  always_comb begin
    first_idx = '0;
    for (int i = NUM_NODES - 1; i >= 0; i--) begin
      if (nodes_i[i]) first_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    start_ok   = 1'b0;
    win_d      = win_q;
    mode_d     = mode_q;
    idx_d      = idx_q;
    best_idx_d = best_idx_q;
    best_cnt_d = best_cnt_q;
    res_we     = 1'b0;
    res_idx    = '0;
    res_cnt    = '0;
    unique case (state_q)
      IDLE: begin
        if (start_i && (window_len_i != '0)) begin
          start_ok   = 1'b1;
          win_d      = window_len_i;
          mode_d     = mode_i;
          idx_d      = '0;
          best_idx_d = '0;
          best_cnt_d = '0;
          state_d    = COUNT;
        end
      end
      COUNT: begin
        win_d = win_q - WIN_W'(1);
        if ((mode_q == MODE_FIRST) && (nodes_i != '0)) begin
          res_we  = 1'b1;
          res_idx = first_idx;
          res_cnt = CNT_W'(1);
          state_d = DONE;
        end else if (win_q == WIN_W'(1)) begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        // Strictly greater keeps ties on the lowest index.
        if (scan_cnt > best_cnt_q) begin
          best_cnt_d = scan_cnt;
          best_idx_d = idx_q;
        end
        if (idx_q == LAST_IDX) begin
          res_we  = 1'b1;
          res_idx = best_idx_d;
          res_cnt = best_cnt_d;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      win_q        <= '0;
      mode_q       <= MODE_MAX;
      idx_q        <= '0;
      best_idx_q   <= '0;
      best_cnt_q   <= '0;
      winner_o     <= '0;
      winner_cnt_o <= '0;
      no_winner_o  <= 1'b0;
      have_result  <= 1'b0;
    end else begin
      win_q      <= win_d;
      mode_q     <= mode_d;
      idx_q      <= idx_d;
      best_idx_q <= best_idx_d;
      best_cnt_q <= best_cnt_d;
      if (start_ok) have_result <= 1'b0;
      if (res_we) begin
        winner_o     <= res_idx;
        winner_cnt_o <= res_cnt;
        no_winner_o  <= (res_cnt == '0);
        have_result  <= 1'b1;
      end
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign valid_o = (state_q == DONE);
  assign spike_o = have_result & ~no_winner_o & nodes_i[winner_o];

endmodule

// File: tb/tb_wta_window_classifier.sv
// Scoreboard bench for wta_window_classifier (4 nodes, plus a 3-bit
// counter instance for saturation).
module tb_wta_window_classifier;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  nodes;
  logic        start, mode, start_s;
  logic [15:0] wlen;

  logic        busy, valid, nw, spike;
  logic [1:0]  winner;
  logic [15:0] wcnt;

  logic        busy_s, valid_s, nw_s, spike_s;
  logic [1:0]  winner_s;
  logic [2:0]  wcnt_s;

  wta_window_classifier #(
    .NUM_NODES(N), .CNT_W(16), .WIN_W(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .nodes_i(nodes),
    .start_i(start), .mode_i(mode), .window_len_i(wlen),
    .busy_o(busy), .valid_o(valid), .winner_o(winner),
    .winner_cnt_o(wcnt), .no_winner_o(nw), .spike_o(spike)
  );

  wta_window_classifier #(
    .NUM_NODES(N), .CNT_W(3), .WIN_W(16)
  ) dut_s (
    .clk_i(clk), .rst_i(rst), .nodes_i(nodes),
    .start_i(start_s), .mode_i(1'b0), .window_len_i(wlen),
    .busy_o(busy_s), .valid_o(valid_s), .winner_o(winner_s),
    .winner_cnt_o(wcnt_s), .no_winner_o(nw_s), .spike_o(spike_s)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] c;
    logic [1:0]  w;
    logic [15:0] n;
    logic        nw;
  } res_t;

  res_t exp_q[$];
  res_t act_q[$];
  logic [3:0] stim[$];

  int n_checks = 0;
  int n_fail   = 0;

  always @(negedge clk) begin
    if (valid === 1'b1) act_q.push_back({cyc, winner, wcnt, nw});
  end

  function automatic string fmt(input res_t r);
    return $sformatf("cyc=%0d win=%0d cnt=%0d nw=%0b", r.c, r.w, r.n, r.nw);
  endfunction

  // Drives one window from stim and pushes the expected result.
  task automatic run_window(input logic m, input int L, input bit poke);
    int   cnt [N];
    int   t0, bc;
    bit   hit;
    logic [3:0] v;
    logic [1:0] bw;
    res_t r;
    hit = 0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    @(negedge clk);
    start = 1'b1; mode = m; wlen = 16'(L); t0 = cyc;
    for (int j = 1; j <= L && !hit; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && j == 2) begin
        start = 1'b1; mode = ~m; wlen = 16'd3;
      end
      v = (stim.size() > 0) ? stim.pop_front() : 4'b0000;
      nodes = v;
      for (int i = 0; i < N; i++) cnt[i] += int'(v[i]);
      if (m && v != 4'b0000) begin
        hit = 1;
        bw = 2'd0;
        for (int i = N - 1; i >= 0; i--) if (v[i]) bw = 2'(i);
        r = {32'(t0 + j + 1), bw, 16'd1, 1'b0};
        exp_q.push_back(r);
      end
    end
    if (!hit) begin
      bw = 2'd0; bc = 0;
      for (int i = 0; i < N; i++) begin
        if (cnt[i] > bc) begin bc = cnt[i]; bw = 2'(i); end
      end
      r = {32'(t0 + L + N + 1), bw, 16'(bc), (bc == 0)};
      exp_q.push_back(r);
      @(negedge clk);
      start = 1'b0; nodes = 4'b0000;
    end
  endtask

  task automatic get_result(output res_t a, output bit ok);
    ok = 0;
    a  = '0;
    for (int k = 0; k < 100 && act_q.size() == 0; k++) @(negedge clk);
    if (act_q.size() > 0) begin
      a  = act_q.pop_front();
      ok = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, valid, winner, wcnt, nw, spike} !== '0) begin
      n_fail++;
      $display("FAIL reset: got busy=%b valid=%b win=%0d cnt=%0d nw=%b spk=%b, want all 0",
               busy, valid, winner, wcnt, nw, spike);
    end
    n_checks++;
    if ({busy_s, valid_s, winner_s, wcnt_s, nw_s, spike_s} !== '0) begin
      n_fail++;
      $display("FAIL reset_sat: got busy=%b cnt=%0d, want all 0", busy_s, wcnt_s);
    end
    rst = 1'b0;
  endtask

  task automatic test_max_count();
    res_t a, e; bit ok;
    stim = '{4'b0100, 4'b0110, 4'b0100, 4'b0110,
             4'b0100, 4'b0010, 4'b0000, 4'b0000};
    run_window(1'b0, 8, 0);
    get_result(a, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || a !== e) begin
      n_fail++;
      $display("FAIL max_count: got %s want %s", ok ? fmt(a) : "timeout", fmt(e));
    end
    @(negedge clk);
    nodes = 4'b0100;
    #1;
    n_checks++;
    if (spike !== 1'b1) begin
      n_fail++; $display("FAIL max_spike_hi: got %b want 1", spike);
    end
    nodes = 4'b1011;
    #1;
    n_checks++;
    if (spike !== 1'b0) begin
      n_fail++; $display("FAIL max_spike_lo: got %b want 0", spike);
    end
    nodes = 4'b0000;
  endtask

  task automatic test_tie();
    res_t a, e; bit ok;
    stim = '{4'b0010, 4'b1000, 4'b1010, 4'b1010, 4'b0010, 4'b1000};
    run_window(1'b0, 6, 0);
    get_result(a, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || a !== e) begin
      n_fail++;
      $display("FAIL tie: got %s want %s", ok ? fmt(a) : "timeout", fmt(e));
    end
  endtask

  task automatic test_first_spike();
    res_t a, e; bit ok;
    stim = '{4'b0000, 4'b0000, 4'b1010};
    run_window(1'b1, 20, 0);
    get_result(a, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || a !== e) begin
      n_fail++;
      $display("FAIL first_spike: got %s want %s", ok ? fmt(a) : "timeout", fmt(e));
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL first_idle: busy got %b want 0", busy);
    end
    nodes = 4'b0010;
    #1;
    n_checks++;
    if (spike !== 1'b1) begin
      n_fail++; $display("FAIL first_spike_hi: got %b want 1", spike);
    end
    nodes = 4'b1101;
    #1;
    n_checks++;
    if (spike !== 1'b0) begin
      n_fail++; $display("FAIL first_spike_lo: got %b want 0", spike);
    end
    nodes = 4'b0000;
  endtask

  task automatic test_all_zero();
    res_t a, e; bit ok;
    stim = {};
    run_window(1'b0, 5, 0);
    get_result(a, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || a !== e) begin
      n_fail++;
      $display("FAIL all_zero: got %s want %s", ok ? fmt(a) : "timeout", fmt(e));
    end
    @(negedge clk);
    nodes = 4'b1111;
    #1;
    n_checks++;
    if (spike !== 1'b0) begin
      n_fail++; $display("FAIL no_winner_spike: got %b want 0", spike);
    end
    nodes = 4'b0000;
  endtask

  task automatic test_zero_len();
    @(negedge clk);
    start = 1'b1; wlen = 16'd0; mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_len: busy got %b want 0", busy);
    end
  endtask

  task automatic test_start_during_count();
    res_t a, e; bit ok;
    stim = '{4'b1000, 4'b1001, 4'b0001, 4'b1000, 4'b1000};
    run_window(1'b0, 5, 1);
    get_result(a, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || a !== e) begin
      n_fail++;
      $display("FAIL start_in_count: got %s want %s", ok ? fmt(a) : "timeout", fmt(e));
    end
  endtask

  task automatic test_back_to_back();
    res_t a, e; bit ok;
    stim = '{4'b0100, 4'b0100, 4'b0100};
    run_window(1'b0, 3, 0);
    for (int k = 0; k < 100 && valid !== 1'b1; k++) @(negedge clk);
    n_checks++;
    if (valid !== 1'b1 || winner !== 2'd2) begin
      n_fail++;
      $display("FAIL b2b_first: got valid=%b win=%0d want valid=1 win=2", valid, winner);
    end
    stim = '{4'b1000, 4'b1000, 4'b0001};
    run_window(1'b0, 3, 0);
    get_result(a, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || a !== e) begin
      n_fail++;
      $display("FAIL b2b_a: got %s want %s", ok ? fmt(a) : "timeout", fmt(e));
    end
    get_result(a, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || a !== e) begin
      n_fail++;
      $display("FAIL b2b_b: got %s want %s", ok ? fmt(a) : "timeout", fmt(e));
    end
  endtask

  task automatic test_reset_mid_scan();
    @(negedge clk);
    start = 1'b1; wlen = 16'd2; mode = 1'b0;
    @(negedge clk);
    start = 1'b0; nodes = 4'b0001;
    @(negedge clk);
    nodes = 4'b0001;
    @(negedge clk);
    nodes = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_scan_busy: got %b want 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, valid, winner, wcnt, nw, spike} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_scan: got busy=%b valid=%b win=%0d cnt=%0d nw=%b, want all 0",
               busy, valid, winner, wcnt, nw);
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_saturation();
    int t0, vc;
    vc = -1;
    @(negedge clk);
    start_s = 1'b1; wlen = 16'd12; t0 = cyc;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      start_s = 1'b0; nodes = 4'b0001;
    end
    @(negedge clk);
    nodes = 4'b0000;
    for (int k = 0; k < 100 && vc < 0; k++) begin
      if (valid_s === 1'b1) vc = cyc;
      else @(negedge clk);
    end
    n_checks++;
    if (vc != t0 + 12 + N + 1 || winner_s !== 2'd0 || wcnt_s !== 3'd7 || nw_s !== 1'b0) begin
      n_fail++;
      $display("FAIL saturation: got cyc=%0d win=%0d cnt=%0d nw=%b want cyc=%0d win=0 cnt=7 nw=0",
               vc, winner_s, wcnt_s, nw_s, t0 + 12 + N + 1);
    end
  endtask

  initial begin
    rst = 1'b1; nodes = '0; start = 1'b0; start_s = 1'b0;
    mode = 1'b0; wlen = '0;
    test_reset();
    test_max_count();
    test_tie();
    test_first_spike();
    test_all_zero();
    test_zero_len();
    test_start_during_count();
    test_back_to_back();
    test_reset_mid_scan();
    test_saturation();
    repeat (5) @(negedge clk);
    n_checks++;
    if (act_q.size() != 0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: got %0d unexpected results, %0d missing, want 0",
               act_q.size(), exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
